// File: rtl/e_mdu.sv
// E-stage multiply/divide unit. Holds the architectural HI/LO registers and
// runs MULT/MULTU/DIV/DIVU over a fixed number of busy cycles; MTHI/MTLO
// complete in the acceptance cycle.
module e_mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [2:0] {
      OpNone, OpMult, OpMultu, OpDiv, OpDivu, OpMthi, OpMtlo, OpRsvd
   } md_op_e;

   localparam logic [3:0] MultN = 4'(MULT_CYCLES);
   localparam logic [3:0] DivN  = 4'(DIV_CYCLES);

   md_op_e      op;
   logic        accept;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic [63:0] prod_s, prod_u;
   logic [31:0] rs_abs, rt_abs, dvd, dvsr, div_q, div_r;
   logic [31:0] res_hi, res_lo;

   assign op     = md_op_e'(md_op);
   assign busy   = (cnt_q != 4'd0);
   assign hi     = hi_q;
   assign lo     = lo_q;
   assign accept = start & ~req & ~busy & (op != OpNone) & (op != OpRsvd);

   // Result datapath: one shared unsigned divider, signs fixed up afterwards.
   always_comb begin
      // Low 64 bits of the sign-extended product equal the signed product.
      prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
      prod_u = {32'd0, rs} * {32'd0, rt};
      rs_abs = rs[31] ? -rs : rs;
      rt_abs = rt[31] ? -rt : rt;
      dvd    = (op == OpDiv) ? rs_abs : rs;
      dvsr   = (op == OpDiv) ? rt_abs : rt;
      // Keep the divider defined on rt=0; that case is overridden below.
      if (dvsr == 32'd0) dvsr = 32'd1;
      div_q  = dvd / dvsr;
      div_r  = dvd % dvsr;
      res_hi = 32'd0;
      res_lo = 32'd0;
      case (op)
         OpMult:  {res_hi, res_lo} = prod_s;
         OpMultu: {res_hi, res_lo} = prod_u;
         OpDiv, OpDivu: begin
            if (rt == 32'd0) begin
               res_hi = rs;
               res_lo = 32'hFFFF_FFFF;
            end else if (op == OpDiv) begin
               // 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
               res_lo = (rs[31] ^ rt[31]) ? -div_q : div_q;
               res_hi = rs[31] ? -div_r : div_r;
            end else begin
               res_lo = div_q;
               res_hi = div_r;
            end
         end
         default: ;
      endcase
   end

   // Next-state: count down while busy and commit on the last busy cycle.
   always_comb begin
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      if (busy) begin
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
         end
      end else if (accept) begin
         case (op)
            OpMult, OpMultu: begin
               pend_hi_d = res_hi;
               pend_lo_d = res_lo;
               cnt_d     = MultN;
            end
            OpDiv, OpDivu: begin
               pend_hi_d = res_hi;
               pend_lo_d = res_lo;
               cnt_d     = DivN;
            end
            OpMthi:  hi_d = rs;
            OpMtlo:  lo_d = rs;
            default: ;
         endcase
      end
   end

   // State registers, cleared asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q     <= 4'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
      end else begin
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
      end
   end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit in the E stage, directly downstream of the D/E pipeline register.
- Consumes E-stage operands (E_RD1 as rs, E_RD2 as rt) plus a decoded MD opcode.
- Runs multi-cycle MULT/MULTU/DIV/DIVU and single-cycle MTHI/MTLO, and holds the architectural HI/LO registers.
- Exports busy to the hazard unit so that later MD instructions stall in D.

Parameters:
- MULT_CYCLES, 5: cycles busy stays high for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10: cycles busy stays high for DIV/DIVU (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- req  input  1  exception/interrupt flush; cancels the instruction currently in E.
- start  input  1  E-stage instruction is an MD operation, qualified by md_op.
- md_op  input  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved.
- rs  input  32  first operand (E_RD1).
- rt  input  32  second operand (E_RD2).
- busy  output  1  multi-cycle operation in progress.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (async, reset=0): hi=0, lo=0, busy=0, internal counter=0, pending result=0. Effect is immediate, not clock-gated.
- Accept condition: start=1, req=0, busy=0, and md_op in 1..6. Any other start is ignored with no state change. md_op 0 or 7 is a no-op.
- MTHI/MTLO accepted in cycle T:
  - hi (or lo) <= rs at the end of T.
  - Never asserts busy.
- MULT/MULTU/DIV/DIVU accepted in cycle T:
  - Result is computed from rs/rt sampled in T and stored in an internal pending register. hi/lo are not yet changed.
  - Counter loads N, where N = MULT_CYCLES or DIV_CYCLES.
  - busy=1 for cycles T+1 .. T+N.
  - In the last busy cycle (counter==1), hi/lo load the pending result at the clock edge and busy falls. New hi/lo are visible in T+N+1, when busy=0.
- Hazard contract: the hazard unit stalls D when busy | (start & md_op in 1..6). mfhi/mflo read hi/lo directly.
- Multiply: 64-bit product, hi=[63:32], lo=[31:0].
  - MULT treats operands as two's complement.
  - MULTU treats operands as unsigned.
- Divide: lo=quotient, hi=remainder.
  - DIV truncates toward zero; the remainder takes the sign of rs.
  - DIVU is unsigned.
- Divide by zero (rt=0), DIV or DIVU: lo=32'hFFFFFFFF, hi=rs.
- Signed overflow (DIV with rs=32'h80000000, rt=32'hFFFFFFFF): lo=32'h80000000, hi=0.
- req:
  - Only affects the acceptance cycle. req=1 with start=1 suppresses the operation entirely, including MTHI/MTLO.
  - req while busy does not abort: the accepted instruction has already left E and is older than the faulting one, so it completes normally.
- start while busy: ignored (hazard unit prevents it). The in-flight operation is unaffected.
- Reset asserted mid-operation: busy drops immediately, hi/lo return to 0, and the pending result is discarded.
- Back-to-back: a new start is accepted in the first cycle with busy=0, i.e. T+N+1.

Test Plan:
- MULT rs=32'hFFFFFFFD (-3), rt=5 -> busy high exactly 5 cycles; then hi=32'hFFFFFFFF, lo=32'hFFFFFFF1. hi/lo unchanged while busy.
- MULTU rs=rt=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001. Same op with MULT -> hi=0, lo=1.
- DIV rs=-7 (32'hFFFFFFF9), rt=2 -> after 10 busy cycles lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU rs=7, rt=2 -> lo=3, hi=1.
- DIV rs=5, rt=0 -> lo=32'hFFFFFFFF, hi=5. DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- req=1 coincident with start (MULT) -> busy stays 0, hi/lo unchanged.
  - req pulsed during cycle 3 of a busy MULT -> result is still written on schedule.
  - MTLO rs=32'h1234 with req=1 -> lo unchanged.
- reset=0 asserted in cycle 4 of a DIV -> busy, hi, lo read 0 in the same cycle.
  - After release, MTHI rs=32'hA5A5A5A5 -> hi=32'hA5A5A5A5 next cycle, with busy never asserted.
